mul_bf16_arbiter: RTL
=====================

# mul_bf16_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one bfloat16 multiplier instance among `N_REQ` requesters. Each requester presents operands and a rounding mode over a valid/ready handshake. The block registers the granted operands, drives the shared multiplier, registers its result and status, and returns them on a single response channel tagged with the requester ID. It sits between the lane front-ends and the shared multiplier; the multiplier stays purely combinational and external.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `N_DATA`, 16, operand/result width (bfloat16)
- `ID_W`, `$clog2(N_REQ)`, requester ID width

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in `N_REQ`: per-requester request valid
- `req_ready` out `N_REQ`: per-requester accept; one-hot or zero
- `req_a` in `N_REQ*N_DATA`: operand A, requester i at `[i*N_DATA +: N_DATA]`
- `req_b` in `N_REQ*N_DATA`: operand B, same packing
- `req_rnd` in `N_REQ*3`: rounding mode, requester i at `[i*3 +: 3]`
- `mul_a`, `mul_b` out `N_DATA`: to the shared multiplier
- `mul_rnd` out 3: to the shared multiplier
- `mul_o` in `N_DATA`: multiplier result, combinational from `mul_a`/`mul_b`/`mul_rnd`
- `mul_status` in 8: multiplier status flags
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response accept
- `rsp_id` out `ID_W`: index of the originating requester
- `rsp_o` out `N_DATA`: product
- `rsp_status` out 8: status captured with the product
- `busy` out 1: `s1_valid | s2_valid`

## Operation
- Stage S1 holds `s1_valid`, `s1_a`, `s1_b`, `s1_rnd`, `s1_id`. It drives `mul_a`/`mul_b`/`mul_rnd`, and drives zeros when `s1_valid`=0.
- Stage S2 holds `s2_valid`, `s2_o`, `s2_status`, `s2_id`. It drives `rsp_*`, with `rsp_valid`=`s2_valid`.
- Pipeline control:
  - `adv2 = !s2_valid | rsp_ready`
  - `adv1 = !s1_valid | adv2`
  - S2 loads from S1 and the multiplier when `adv2`. `s2_valid <= s1_valid`.
  - S1 loads the granted request when `adv1`. `s1_valid <=` "any grant".
- Arbitration:
  - Round-robin pointer `ptr` (`ID_W` bits, reset 0). The grant goes to the first asserted `req_valid[j]` scanning j = ptr, ptr+1, … modulo `N_REQ`.
  - `req_ready[j] = grant[j] & adv1`.
  - On a handshake with requester g, `ptr <= (g == N_REQ-1) ? 0 : g+1`. Without a handshake `ptr` holds.
- `req_ready` never depends on `req_valid` of the same requester except through arbitration. Requesters must keep `req_valid` and their data stable until accepted. A withdrawn request is not an error; arbitration simply re-evaluates.
- Backpressure: while `rsp_valid & !rsp_ready`, S2 holds. If S1 is also full it holds too, and all `req_ready` are 0. Nothing is ever dropped or duplicated.
- Responses return strictly in acceptance order. There is no reordering and no per-requester response routing; consumers decode `rsp_id`.
- Reset, asynchronous and effective immediately:
  - `s1_valid`, `s2_valid`, `ptr`, and all data registers clear to 0.
  - Outputs during reset: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_o`=0, `rsp_status`=0, `mul_*`=0, `busy`=0.
  - In-flight operations are discarded.

## Timing
- Latency: a handshake at edge k gives `rsp_valid`=1 after edge k+1, when S1 moves to S2. The response is visible in the cycle following k+1, i.e. 2 cycles from request presentation.
- Throughput: 1 accept per cycle while `rsp_ready`=1 continuously.
- Simultaneous S2 drain, S1→S2 move and new accept in one cycle are legal and required for full throughput.
- Critical path: S1 regs → multiplier → S2 regs. There is no combinational path from `req_*` to `rsp_*`.
- `req_ready` is combinational from `req_valid`, `ptr`, `s1_valid`, `s2_valid` and `rsp_ready`.

## Test plan
- Single request: requester 2 sends a=0x3F80 (1.0), b=0x4000 (2.0), rnd=0, `rsp_ready`=1 → `req_ready[2]` high in cycle 0; `rsp_valid`, `rsp_id`=2 and `rsp_o`=0x4000 two cycles later; `busy` falls one cycle after that.
- Fairness: all 4 requesters hold `req_valid` for 8 accepts from reset → grant order 0,1,2,3,0,1,2,3; `ptr` wraps 3→0.
- Skip: only requesters 1 and 3 valid with ptr=2 → grant 3, then 1, then 3.
- Backpressure: stream of 4 requests with `rsp_ready` held 0 → exactly 2 accepted; `req_ready` then 0. After releasing `rsp_ready`, 4 responses arrive in order with correct IDs; nothing is lost.
- Status/rounding passthrough: a=0x7F80 (+inf), b=0x0000, rnd=3 → `mul_rnd`=3 while in S1; `rsp_status` equals the multiplier's invalid-flag vector; `rsp_o` is NaN.
- Reset mid-operation: assert `rst_n`=0 with both stages full → `rsp_valid`, `busy` and `req_ready` are 0 immediately, not waiting for a clock edge. After release, the first grant goes to requester 0 (ptr=0) and no stale response appears.

Source files
------------

// File: rtl/mul_bf16_arbiter.sv
// mul_bf16_arbiter
// Shares one external, purely combinational bfloat16 multiplier among N_REQ
// requesters. A round-robin arbiter picks one request per cycle. The request
// goes into stage S1, which drives the multiplier. The product and status are
// captured into stage S2, which drives the single response channel tagged
// with the requester index. Responses leave in acceptance order.
module mul_bf16_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_DATA = 16,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*N_DATA-1:0] req_a,
  input  logic [N_REQ*N_DATA-1:0] req_b,
  input  logic [N_REQ*3-1:0]      req_rnd,
  output logic [N_DATA-1:0]       mul_a,
  output logic [N_DATA-1:0]       mul_b,
  output logic [2:0]              mul_rnd,
  input  logic [N_DATA-1:0]       mul_o,
  input  logic [7:0]              mul_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [N_DATA-1:0]       rsp_o,
  output logic [7:0]              rsp_status,
  output logic                    busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  // Round-robin pick: {found, index} of the first valid requester at or after
  // 'start', wrapping modulo N_REQ. Scanning from the far end lets the entry
  // closest to 'start' overwrite the others.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  start);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_REQ;
      if (valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  // Pointer value after granting requester g: the one just after g, wrapping.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g);
    return (g == LAST_ID) ? '0 : g + ID_W'(1);
  endfunction

  // Arbitration state
  logic [ID_W-1:0]   ptr_q, ptr_d;

  // Stage S1: accepted operands, feeding the shared multiplier
  logic              s1_valid_q, s1_valid_d;
  logic [N_DATA-1:0] s1_a_q, s1_a_d;
  logic [N_DATA-1:0] s1_b_q, s1_b_d;
  logic [2:0]        s1_rnd_q, s1_rnd_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;

  // Stage S2: captured product, feeding the response channel
  logic              s2_valid_q, s2_valid_d;
  logic [N_DATA-1:0] s2_o_q, s2_o_d;
  logic [7:0]        s2_status_q, s2_status_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;

  // Arbitration and pipeline control
  logic [ID_W:0]     pick;
  logic              any_grant;
  logic [ID_W-1:0]   grant_id;
  logic [N_REQ-1:0]  grant_oh;
  logic              adv1, adv2, accept;
  logic [N_DATA-1:0] sel_a, sel_b;
  logic [2:0]        sel_rnd;

  // Grant decision, stage advance conditions and per-requester ready.
  // Ready is forced low while reset is asserted so no requester sees an
  // accept it could act on during reset.
  always_comb begin
    pick      = rr_pick(req_valid, ptr_q);
    any_grant = pick[ID_W];
    grant_id  = pick[ID_W-1:0];
    grant_oh  = any_grant ? (N_REQ'(1) << grant_id) : '0;
    adv2      = !s2_valid_q || rsp_ready;
    adv1      = !s1_valid_q || adv2;
    accept    = any_grant && adv1;
    req_ready = grant_oh & {N_REQ{adv1 && rst_n}};
  end

  // Operand mux: select the granted requester's packed fields.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_rnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a   = req_a[i*N_DATA +: N_DATA];
        sel_b   = req_b[i*N_DATA +: N_DATA];
        sel_rnd = req_rnd[i*3 +: 3];
      end
    end
  end

  // Next-state for the pointer and both pipeline stages.
  always_comb begin
    ptr_d       = accept ? rr_next(grant_id) : ptr_q;

    // ---- arbiter -> S1 ----
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_rnd_d    = s1_rnd_q;
    s1_id_d     = s1_id_q;
    if (adv1) begin
      s1_valid_d = any_grant;
      if (any_grant) begin
        s1_a_d   = sel_a;
        s1_b_d   = sel_b;
        s1_rnd_d = sel_rnd;
        s1_id_d  = grant_id;
      end
    end

    // ---- S1 + multiplier -> S2 ----
    s2_valid_d  = s2_valid_q;
    s2_o_d      = s2_o_q;
    s2_status_d = s2_status_q;
    s2_id_d     = s2_id_q;
    if (adv2) begin
      s2_valid_d  = s1_valid_q;
      s2_o_d      = mul_o;
      s2_status_d = mul_status;
      s2_id_d     = s1_id_q;
    end
  end

  // State registers. Reset clears everything so outputs read zero at once and
  // in-flight operations are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_rnd_q    <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_o_q      <= '0;
      s2_status_q <= '0;
      s2_id_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_o_q      <= s2_o_d;
      s2_status_q <= s2_status_d;
      s2_id_q     <= s2_id_d;
    end
  end

  // Output drive: multiplier inputs are zero whenever S1 is empty.
  always_comb begin
    mul_a      = s1_valid_q ? s1_a_q   : '0;
    mul_b      = s1_valid_q ? s1_b_q   : '0;
    mul_rnd    = s1_valid_q ? s1_rnd_q : '0;
    rsp_valid  = s2_valid_q;
    rsp_id     = s2_id_q;
    rsp_o      = s2_o_q;
    rsp_status = s2_status_q;
    busy       = s1_valid_q || s2_valid_q;
  end

endmodule
